// File: rtl/button_conditioner.sv
// Six-button front end: 2-flop synchroniser, per-button debounce FSM, press/release pulses.
// Define BTN_AUTOREPEAT_EN to add auto-repeat press pulses on bits selected by REPEAT_MASK.

module button_conditioner_lane #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter bit RPT_EN          = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic level_o,
    output logic press_o,
    output logic release_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {IDLE, ARM, HELD, DISARM} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic          press_q;
    logic          release_q;

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DELAY_M1 = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_M1  = RW'(REPEAT_RATE - 1);

    logic [RW-1:0] rpt_cnt_q;
    logic          rpt_first_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rpt_cnt_q   <= '0;
            rpt_first_q <= 1'b0;
`endif
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (raw_i) begin
                        state_q <= ARM;
                        cnt_q   <= CW'(1);
                    end
                end
                ARM: begin
                    if (!raw_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
                        rpt_cnt_q   <= '0;
                        rpt_first_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                HELD: begin
                    if (!raw_i) begin
                        state_q <= DISARM;
                        cnt_q   <= CW'(1);
                    end
`ifdef BTN_AUTOREPEAT_EN
                    // Cadence only advances while steadily held; DISARM freezes it.
                    else if (RPT_EN) begin
                        if (rpt_cnt_q == (rpt_first_q ? DELAY_M1 : RATE_M1)) begin
                            press_q     <= 1'b1;
                            rpt_cnt_q   <= '0;
                            rpt_first_q <= 1'b0;
                        end else begin
                            rpt_cnt_q <= rpt_cnt_q + RW'(1);
                        end
                    end
`endif
                end
                DISARM: begin
                    if (raw_i) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_q   <= IDLE;
                        cnt_q     <= '0;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
endmodule

module button_conditioner #(
    parameter int         DEBOUNCE_CYCLES = 50000,
    parameter int         REPEAT_DELAY    = 25000000,
    parameter int         REPEAT_RATE     = 5000000,
    parameter logic [5:0] REPEAT_MASK     = 6'b000011
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] btn_n_i,
    output logic [5:0] level_o,
    output logic [5:0] press_o,
    output logic [5:0] release_o
);
    logic [5:0] sync1_q;
    logic [5:0] sync2_q;
    logic [5:0] raw_s;

    // Reset to released so a button held through reset re-qualifies from scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_n_i;
            sync2_q <= sync1_q;
        end
    end

    assign raw_s = ~sync2_q;

    for (genvar i = 0; i < 6; i++) begin : g_lane
        button_conditioner_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE),
            .RPT_EN         (REPEAT_MASK[i])
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw_i    (raw_s[i]),
            .level_o  (level_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i])
        );
    end
endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length reference model checked every cycle,
// plus directed latency, bounce, simultaneity, reset and auto-repeat scenarios.

module tb_button_conditioner;
    localparam int         D    = 4;
    localparam int         RD   = 20;
    localparam int         RR   = 8;
    localparam logic [5:0] MASK = 6'b000011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] btn_n = '1;
    logic [5:0] level, press, rel;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .REPEAT_MASK    (MASK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_n_i  (btn_n),
        .level_o  (level),
        .press_o  (press),
        .release_o(rel)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once D+1 consecutive synchronised samples disagree with it.
    logic [5:0] m_s1, m_s2, m_lvl, m_press, m_rel;
    int m_run [6];
    int m_hc  [6];
    bit m_first [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '1; m_s2 = '1; m_lvl = '0; m_press = '0; m_rel = '0;
        for (int b = 0; b < 6; b++) begin
            m_run[b] = 0; m_hc[b] = 0; m_first[b] = 1'b0;
        end
    endtask

    task automatic model_step();
        logic [5:0] raw;
        bit glitch;
        raw  = ~m_s2;
        m_s2 = m_s1;
        m_s1 = btn_n;
        m_press = '0;
        m_rel   = '0;
        for (int b = 0; b < 6; b++) begin
            if (raw[b] != m_lvl[b]) begin
                m_run[b]++;
                if (m_run[b] == D + 1) begin
                    m_run[b] = 0;
                    m_lvl[b] = ~m_lvl[b];
                    if (m_lvl[b]) begin
                        m_press[b] = 1'b1; m_hc[b] = 0; m_first[b] = 1'b1;
                    end else begin
                        m_rel[b] = 1'b1;
                    end
                end
            end else begin
                glitch   = (m_run[b] > 0);
                m_run[b] = 0;
`ifdef BTN_AUTOREPEAT_EN
                if (m_lvl[b] && MASK[b] && !glitch) begin
                    m_hc[b]++;
                    if (m_hc[b] == (m_first[b] ? RD : RR)) begin
                        m_press[b] = 1'b1; m_hc[b] = 0; m_first[b] = 1'b0;
                    end
                end
`else
                if (glitch) m_hc[b] = 0;
`endif
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        chk("level", level, m_lvl);
        chk("press", press, m_press);
        chk("release", rel, m_rel);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Latency in edges from the first edge that samples the new input to the pulse.
    task automatic wait_pulse(input int b, input bit is_press, output int lat);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            cycle();
            if ((is_press ? press[b] : rel[b]) === 1'b1) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk("pulse_timeout", 32'(b), 32'hffff);
    endtask

    int lat;
    int cnt_up, cnt_left;
    int dur [6];

    initial begin
        model_reset();
        #1;
        chk("rst_level", level, 0);
        chk("rst_press", press, 0);
        chk("rst_release", rel, 0);
        idle(3);
        rst_n = 1'b1;
        idle(8);

        // Basic press and release latency on up
        btn_n[0] = 1'b0;
        wait_pulse(0, 1'b1, lat);
        chk("press_lat", 32'(lat), D + 2);
        chk("press_level", 32'(level[0]), 1);
        idle(30);
        btn_n[0] = 1'b1;
        wait_pulse(0, 1'b0, lat);
        chk("release_lat", 32'(lat), D + 2);
        chk("release_level", 32'(level[0]), 0);
        idle(6);

        // Bounce on left: runs shorter than the window never qualify
        for (int r = 0; r < 2; r++) begin
            btn_n[2] = 1'b0; idle(3);
            btn_n[2] = 1'b1; idle(1);
        end
        chk("bounce_level", 32'(level[2]), 0);
        btn_n[2] = 1'b0;
        wait_pulse(2, 1'b1, lat);
        chk("bounce_lat", 32'(lat), D + 2);
        btn_n[2] = 1'b1;
        idle(12);

        // Simultaneous up + esc
        btn_n[0] = 1'b0; btn_n[5] = 1'b0;
        wait_pulse(0, 1'b1, lat);
        chk("simul_lat", 32'(lat), D + 2);
        chk("simul_esc", 32'(press[5]), 1);
        idle(4);

        // Reset while up is held
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_out", {level, press, rel}, 0);
        idle(3);
        rst_n = 1'b1;
        wait_pulse(0, 1'b1, lat);
        chk("rst_held_lat", 32'(lat), D + 2);
        btn_n = '1;
        idle(12);

        // Held glitch on down: no release
        btn_n[1] = 1'b0;
        wait_pulse(1, 1'b1, lat);
        idle(3);
        btn_n[1] = 1'b1; idle(2);
        btn_n[1] = 1'b0; idle(10);
        chk("glitch_level", 32'(level[1]), 1);
        btn_n[1] = 1'b1;
        idle(12);

        // Auto-repeat: up repeats only with the feature built in, left never does
        btn_n[0] = 1'b0; btn_n[2] = 1'b0;
        wait_pulse(0, 1'b1, lat);
        cnt_up = 0; cnt_left = 0;
        for (int i = 0; i < 58; i++) begin
            cycle();
            if (press[0] === 1'b1) cnt_up++;
            if (press[2] === 1'b1) cnt_left++;
        end
`ifdef BTN_AUTOREPEAT_EN
        chk("repeat_up", 32'(cnt_up), 5);
`else
        chk("repeat_up", 32'(cnt_up), 0);
`endif
        chk("repeat_left", 32'(cnt_left), 0);
        btn_n = '1;
        idle(12);

        // Random per-bit hold/bounce durations, occasionally long enough to repeat
        for (int b = 0; b < 6; b++) dur[b] = $urandom_range(1, 8);
        for (int i = 0; i < 4000; i++) begin
            cycle();
            for (int b = 0; b < 6; b++) begin
                if (dur[b] == 0) begin
                    btn_n[b] = ~btn_n[b];
                    dur[b] = ($urandom_range(0, 5) == 0) ? $urandom_range(20, 60)
                                                         : $urandom_range(1, 8);
                end else begin
                    dur[b]--;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
